// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV64I immediate decoder feeding a small output queue.
// Decode happens at enqueue; the queue head drives the outputs directly.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instruction,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          imm,
  output logic [2:0]               fmt,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("imm_gen_pipe: DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } ent_t;

  ent_t              mem [DEPTH];
  ent_t              dec;
  ent_t              head;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              rdy_q;
  logic              push;
  logic              pop;
  logic [31:0]       i;
  logic [6:0]        op;
  logic signed [31:0] v;
  logic is_r, is_i, is_s, is_b, is_u, is_j;

  assign i  = instruction;
  assign op = i[6:0];

  assign is_r = op inside {7'b0110011, 7'b0111011};
  assign is_i = op inside {7'b0010011, 7'b0011011,
                           7'b0000011, 7'b1100111};
  assign is_s = (op == 7'b0100011);
  assign is_b = (op == 7'b1100011);
  assign is_u = op inside {7'b0110111, 7'b0010111};
  assign is_j = (op == 7'b1101111);

  always_comb begin
    dec = '0;
    v   = '0;
    unique case (1'b1)
      is_r: dec.fmt = 3'd0;
      is_i: begin
        dec.fmt = 3'd1;
        v = {{20{i[31]}}, i[31:20]};
      end
      is_s: begin
        dec.fmt = 3'd2;
        v = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      is_b: begin
        dec.fmt = 3'd3;
        v = {{19{i[31]}}, i[31], i[7],
             i[30:25], i[11:8], 1'b0};
      end
      is_u: begin
        dec.fmt = 3'd4;
        v = {i[31:12], 12'b0};
      end
      is_j: begin
        dec.fmt = 3'd5;
        v = {{11{i[31]}}, i[31], i[19:12],
             i[20], i[30:21], 1'b0};
      end
      default: begin
        dec.fmt = 3'd7;
        dec.ill = 1'b1;
      end
    endcase
    // signed size cast sign-extends from bit 31
    dec.imm = XLEN'(v);
  end

  assign out_valid = (count != '0);
  assign in_ready  = rdy_q && (count < CW'(DEPTH));
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
      if (push && dec.ill && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= dec;
  end

  assign head    = mem[rptr];
  assign imm     = out_valid ? head.imm : '0;
  assign fmt     = out_valid ? head.fmt : 3'd0;
  assign illegal = out_valid ? head.ill : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and randomized checks of imm_gen_pipe
// against a queue-based reference model.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } ent_t;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: XLEN=64, DEPTH=2, CNT_W=2
  logic        rst_a, fl_a, iv_a, ir_a, ov_a, or_a, ill_a;
  logic [31:0] ins_a;
  logic [63:0] imm_a;
  logic [2:0]  fmt_a;
  logic [1:0]  cnt_a;
  logic [1:0]  err_a;

  // instance B: XLEN=32, DEPTH=4, CNT_W=16
  logic        rst_b, fl_b, iv_b, ir_b, ov_b, or_b, ill_b;
  logic [31:0] ins_b;
  logic [31:0] imm_b;
  logic [2:0]  fmt_b;
  logic [2:0]  cnt_b;
  logic [15:0] err_b;

  imm_gen_pipe #(.XLEN(64), .DEPTH(2), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_a), .flush(fl_a),
    .in_valid(iv_a), .in_ready(ir_a), .instruction(ins_a),
    .out_valid(ov_a), .out_ready(or_a), .imm(imm_a),
    .fmt(fmt_a), .illegal(ill_a), .count(cnt_a),
    .err_cnt(err_a)
  );

  imm_gen_pipe #(.XLEN(32), .DEPTH(4), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_b), .flush(fl_b),
    .in_valid(iv_b), .in_ready(ir_b), .instruction(ins_b),
    .out_valid(ov_b), .out_ready(or_b), .imm(imm_b),
    .fmt(fmt_b), .illegal(ill_b), .count(cnt_b),
    .err_cnt(err_b)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // reference decode, written as arithmetic on the signed word
  function automatic ent_t ref_dec(input logic [31:0] w,
                                   input int xl);
    ent_t   e;
    longint s;
    longint v;
    s = longint'($signed(w));
    v = 0;
    e.fmt = 3'd7;
    e.ill = 1'b1;
    case (w[6:0])
      7'h13, 7'h1B, 7'h03, 7'h67: begin
        e.fmt = 3'd1; e.ill = 1'b0;
        v = s >>> 20;
      end
      7'h23: begin
        e.fmt = 3'd2; e.ill = 1'b0;
        v = (s >>> 25) * 32 + longint'(w[11:7]);
      end
      7'h63: begin
        e.fmt = 3'd3; e.ill = 1'b0;
        v = (s >>> 31) * 4096 + longint'(w[7]) * 2048
          + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4; e.ill = 1'b0;
        v = longint'($signed(w & 32'hFFFFF000));
      end
      7'h6F: begin
        e.fmt = 3'd5; e.ill = 1'b0;
        v = (s >>> 31) * 1048576 + longint'(w[19:12]) * 4096
          + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
      end
      7'h33, 7'h3B: begin
        e.fmt = 3'd0; e.ill = 1'b0;
      end
      default: ;
    endcase
    if (xl == 32) v = v & 64'hFFFFFFFF;
    e.imm = v;
    return e;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    logic [6:0]  o;
    r = $urandom;
    case ($urandom_range(0, 12))
      0: o = 7'h13;  1: o = 7'h1B;  2: o = 7'h03;
      3: o = 7'h67;  4: o = 7'h23;  5: o = 7'h63;
      6: o = 7'h37;  7: o = 7'h17;  8: o = 7'h6F;
      9: o = 7'h33; 10: o = 7'h3B; 11: o = 7'h00;
      default: o = 7'($urandom);
    endcase
    r[6:0] = o;
    return r;
  endfunction

  logic [31:0] w38 [5];
  logic [63:0] e38 [5];
  logic [2:0]  f38 [5];
  ent_t        q [$];
  ent_t        e;
  int          merr;
  logic        psh, pp;

  initial begin
    w38[0] = 32'hFFF00093; e38[0] = 64'hFFFFFFFFFFFFFFFF; f38[0] = 3'd1;
    w38[1] = 32'hFE113C23; e38[1] = 64'hFFFFFFFFFFFFFFF8; f38[1] = 3'd2;
    w38[2] = 32'hFE000EE3; e38[2] = 64'hFFFFFFFFFFFFFFFC; f38[2] = 3'd3;
    w38[3] = 32'h123450B7; e38[3] = 64'h0000000012345000; f38[3] = 3'd4;
    w38[4] = 32'hFF5FF0EF; e38[4] = 64'hFFFFFFFFFFFFFFF4; f38[4] = 3'd5;

    rst_a = 0; fl_a = 0; iv_a = 0; or_a = 0; ins_a = '0;
    rst_b = 0; fl_b = 0; iv_b = 0; or_b = 0; ins_b = '0;
    #3;
    chk("rst_count", cnt_a, 0);
    chk("rst_ovalid", ov_a, 0);
    chk("rst_iready", ir_a, 0);
    chk("rst_imm", imm_a, 0);
    chk("rst_err", err_a, 0);
    @(negedge clk);
    rst_a = 1; rst_b = 1;
    #1;
    chk("iready_before_edge", ir_a, 0);
    tick();
    chk("iready_after_edge", ir_a, 1);
    chk("iready_b_after_edge", ir_b, 1);

    // back-to-back decode with out_ready=1
    or_a = 1;
    for (int k = 0; k < 5; k++) begin
      iv_a = 1; ins_a = w38[k];
      tick();
      chk($sformatf("seq_imm%0d", k), imm_a, e38[k]);
      chk($sformatf("seq_fmt%0d", k), fmt_a, f38[k]);
    end
    iv_a = 0;
    tick();
    chk("seq_drained", ov_a, 0);

    // backpressure: fill, hold, release one
    or_a = 0;
    iv_a = 1; ins_a = 32'hFFF00093; tick();
    ins_a = 32'h123450B7; tick();
    iv_a = 0;
    chk("full_iready", ir_a, 0);
    chk("full_count", cnt_a, 2);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_imm", imm_a, 64'hFFFFFFFFFFFFFFFF);
      chk("hold_fmt", fmt_a, 1);
    end
    or_a = 1; tick(); or_a = 0;
    chk("pop1_count", cnt_a, 1);
    chk("pop1_iready", ir_a, 1);
    chk("pop1_imm", imm_a, 64'h12345000);
    or_a = 1; tick(); or_a = 0;
    chk("empty_count", cnt_a, 0);
    chk("empty_imm", imm_a, 0);
    chk("empty_fmt", fmt_a, 0);

    // illegal opcodes then an add
    or_a = 1; iv_a = 1;
    ins_a = 32'h00000000; tick();
    chk("ill0_fmt", fmt_a, 7);
    chk("ill0_ill", ill_a, 1);
    chk("ill0_imm", imm_a, 0);
    ins_a = 32'hFFFFFF80; tick();
    chk("ill1_fmt", fmt_a, 7);
    chk("ill1_ill", ill_a, 1);
    ins_a = 32'h00208033; tick();
    chk("add_fmt", fmt_a, 0);
    chk("add_ill", ill_a, 0);
    chk("add_err", err_a, 2);
    iv_a = 0; tick();

    // saturation from a fresh reset
    rst_a = 0; #1;
    chk("rst2_err", err_a, 0);
    chk("rst2_ovalid", ov_a, 0);
    @(negedge clk); rst_a = 1; tick();
    for (int k = 1; k <= 5; k++) begin
      iv_a = 1; ins_a = $urandom & 32'hFFFFFF80;
      tick();
      chk($sformatf("sat_err%0d", k), err_a, (k > 3) ? 3 : k);
    end
    iv_a = 0; tick();

    // flush behaviour from a fresh reset
    rst_a = 0; @(negedge clk); rst_a = 1; tick();
    or_a = 0; iv_a = 1; ins_a = 32'hFFF00093; tick();
    fl_a = 1; ins_a = 32'h00000000; or_a = 1; tick();
    fl_a = 0; iv_a = 0; or_a = 0;
    chk("flush1_count", cnt_a, 0);
    chk("flush1_ovalid", ov_a, 0);
    chk("flush1_err", err_a, 0);
    iv_a = 1; ins_a = 32'hFFF00093; tick(); tick();
    chk("fill_count", cnt_a, 2);
    fl_a = 1; ins_a = 32'h00000000; tick();
    fl_a = 0; iv_a = 0;
    chk("flush2_count", cnt_a, 0);
    chk("flush2_ovalid", ov_a, 0);
    chk("flush2_imm", imm_a, 0);
    chk("flush2_err", err_a, 0);
    iv_a = 1; ins_a = 32'h123450B7; tick(); iv_a = 0;
    chk("post_flush_imm", imm_a, 64'h12345000);
    or_a = 1; tick(); or_a = 0;

    // randomized run against the queue model
    q.delete(); merr = 0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd_ovalid", ov_a, q.size() != 0);
      chk("rnd_count", cnt_a, q.size());
      chk("rnd_iready", ir_a, q.size() < 2);
      chk("rnd_err", err_a, merr);
      if (q.size() != 0) begin
        chk("rnd_imm", imm_a, q[0].imm);
        chk("rnd_fmt", fmt_a, q[0].fmt);
        chk("rnd_ill", ill_a, q[0].ill);
      end else begin
        chk("rnd_imm0", imm_a, 0);
      end
      iv_a  = ($urandom_range(0, 3) != 0);
      or_a  = ($urandom_range(0, 2) != 0);
      fl_a  = ($urandom_range(0, 19) == 0);
      ins_a = rand_ins();
      e   = ref_dec(ins_a, 64);
      psh = iv_a && q.size() < 2 && !fl_a;
      pp  = or_a && q.size() != 0 && !fl_a;
      tick();
      if (fl_a) q.delete();
      else begin
        if (pp)  void'(q.pop_front());
        if (psh) q.push_back(e);
      end
      if (psh && e.ill && merr < 3) merr++;
    end
    iv_a = 0; or_a = 0; fl_a = 0;

    // XLEN=32 lui, then reset mid-stream
    or_b = 0; iv_b = 1;
    ins_b = 32'hFFFFF0B7; tick();
    ins_b = 32'hFFF00093; tick();
    iv_b = 0;
    chk("x32_lui_imm", imm_b, 64'hFFFFF000);
    chk("x32_lui_fmt", fmt_b, 4);
    chk("x32_count", cnt_b, 2);
    or_b = 1; iv_b = 1; ins_b = 32'hFFF00093;
    #2; rst_b = 0; #1;
    chk("x32_rst_ovalid", ov_b, 0);
    chk("x32_rst_count", cnt_b, 0);
    chk("x32_rst_imm", imm_b, 0);
    chk("x32_rst_iready", ir_b, 0);
    iv_b = 0; or_b = 0;
    @(negedge clk); rst_b = 1; #1;
    chk("x32_iready_pre", ir_b, 0);
    tick();
    chk("x32_iready_post", ir_b, 1);
    chk("x32_ovalid_post", ov_b, 0);
    iv_b = 1; ins_b = 32'hFFF00093; tick(); iv_b = 0;
    chk("x32_addi_imm", imm_b, 64'hFFFFFFFF);
    e = ref_dec(32'hFF5FF0EF, 32);
    iv_b = 1; ins_b = 32'hFF5FF0EF; or_b = 1; tick(); iv_b = 0;
    chk("x32_jal_imm", imm_b, e.imm);
    tick(); or_b = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
